// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one single-ported memory between an instruction
// fetch port and a data load/store port. One access in flight at a time,
// sequenced IDLE -> ACCESS -> RESP, so grant to response is always two cycles.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on a tie.
// Without it, data wins ties but fetch is forced through after STARVE_MAX
// consecutive data grants made while fetch was waiting.
//
// Memory data is right-justified: byte/half accesses use the low lanes and
// the memory resolves the byte address itself.

module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,

  // Instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,

  // Data port
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,

  // Memory port
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_wr,
  input  logic [31:0] mem_data_out
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q;

  // Registered request of the access in flight
  logic        owner_data_q;  // 1 = data port owns the access
  logic        wr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Response registers, non-zero only during RESP
  logic        if_rvalid_q;
  logic [31:0] if_rdata_q;
  logic        d_rvalid_q;
  logic [31:0] d_rdata_q;
  logic        d_err_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        last_data_q;   // 1 = data port won the most recent grant
`else
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  logic [3:0]  starve_q;      // data grants issued while fetch was waiting
`endif

  logic        pick_data;
  logic        grant_ok;
  logic        d_err_in;
  logic        in_access;
  logic        access_ok;
  logic [31:0] load_ext;

  // Arbitration between the two requesters, only meaningful in IDLE
  always_comb begin
    pick_data = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie, favour whichever port did not win last time
    pick_data = d_req & (~if_req | ~last_data_q);
`else
    // Data wins ties until fetch has been passed over StarveMax times
    pick_data = d_req & (~if_req | (starve_q < StarveMax));
`endif
  end

  // Grants are combinational pulses in IDLE; rst gates them so reset forces
  // every output low immediately
  assign grant_ok = rst & (state_q == StIdle);
  assign d_gnt    = grant_ok & pick_data;
  assign if_gnt   = grant_ok & if_req & ~pick_data;

  // Misaligned half/word or the reserved size code
  assign d_err_in = (d_size == 2'b11) ||
                    ((d_size == SizeHalf) && d_addr[0]) ||
                    ((d_size == SizeWord) && (d_addr[1:0] != 2'b00));

  assign in_access = (state_q == StAccess);
  assign access_ok = in_access & ~err_q;

  // Memory drive: only during ACCESS, and an erroring access touches no lanes
  always_comb begin
    mem_addr        = '0;
    mem_data_in     = '0;
    mem_byte_enable = 4'b0000;
    mem_wr          = 1'b0;
    if (in_access) begin
      mem_addr = addr_q;
    end
    if (access_ok) begin
      case (size_q)
        SizeByte: mem_byte_enable = 4'b0001;
        SizeHalf: mem_byte_enable = 4'b0011;
        SizeWord: mem_byte_enable = 4'b1111;
        default:  mem_byte_enable = 4'b0000;
      endcase
      mem_wr = wr_q;
      if (wr_q) begin
        case (size_q)
          SizeByte: mem_data_in = {24'h000000, wdata_q[7:0]};
          SizeHalf: mem_data_in = {16'h0000, wdata_q[15:0]};
          default:  mem_data_in = wdata_q;
        endcase
      end
    end
  end

  // Zero/sign extension of load data from the low lanes
  always_comb begin
    load_ext = '0;
    case (size_q)
      SizeByte: load_ext = {{24{signed_q & mem_data_out[7]}}, mem_data_out[7:0]};
      SizeHalf: load_ext = {{16{signed_q & mem_data_out[15]}}, mem_data_out[15:0]};
      SizeWord: load_ext = mem_data_out;
      default:  load_ext = '0;
    endcase
  end

  // Sequencer: capture on grant, sample memory at end of ACCESS, respond in RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_data_q <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
      d_err_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_data_q  <= 1'b0;
`else
      starve_q     <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (d_gnt) begin
            state_q      <= StAccess;
            owner_data_q <= 1'b1;
            wr_q         <= d_wr;
            size_q       <= d_size;
            signed_q     <= d_signed;
            err_q        <= d_err_in;
            addr_q       <= d_addr;
            wdata_q      <= d_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_q  <= 1'b1;
`else
            if (if_req && (starve_q != StarveMax)) begin
              starve_q <= starve_q + 4'd1;
            end
`endif
          end else if (if_gnt) begin
            // Fetches are always aligned word loads and never error
            state_q      <= StAccess;
            owner_data_q <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= SizeWord;
            signed_q     <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= if_addr;
            wdata_q      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_q  <= 1'b0;
`else
            starve_q     <= '0;
`endif
          end
        end
        StAccess: begin
          state_q <= StResp;
          if (owner_data_q) begin
            d_rvalid_q <= 1'b1;
            d_err_q    <= err_q;
            d_rdata_q  <= (err_q || wr_q) ? 32'h0 : load_ext;
          end else begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= mem_data_out;
          end
        end
        StResp: begin
          state_q     <= StIdle;
          if_rvalid_q <= 1'b0;
          if_rdata_q  <= '0;
          d_rvalid_q  <= 1'b0;
          d_rdata_q   <= '0;
          d_err_q     <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small right-justified memory model.
// Inputs change 1 time unit after a rising edge; outputs are checked after
// they settle, well before the next edge.

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_byte_enable;
  logic        mem_wr;
  logic [31:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STARVE_MAX(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_gnt          (if_gnt),
    .if_rvalid       (if_rvalid),
    .if_rdata        (if_rdata),
    .d_req           (d_req),
    .d_wr            (d_wr),
    .d_size          (d_size),
    .d_signed        (d_signed),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_gnt           (d_gnt),
    .d_rvalid        (d_rvalid),
    .d_rdata         (d_rdata),
    .d_err           (d_err),
    .mem_addr        (mem_addr),
    .mem_data_in     (mem_data_in),
    .mem_byte_enable (mem_byte_enable),
    .mem_wr          (mem_wr),
    .mem_data_out    (mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory model: a few addressed words, combinational read, lane-masked write
  localparam int NMem = 8;
  localparam logic [31:0] MemAddr [NMem] = '{
    32'h100, 32'h203, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h201, 32'h300
  };
  logic [31:0] mem_words [NMem] = '{
    32'hDEADBEEF, 32'hAABBCC80, 32'h12348001, 32'h80000001,
    32'h00000000, 32'h11223344, 32'h55667788, 32'h0F0F0F0F
  };

  always_comb begin
    mem_data_out = '0;
    for (int i = 0; i < NMem; i++) begin
      if (MemAddr[i] == mem_addr) mem_data_out = mem_words[i];
    end
  end

  always @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < NMem; i++) begin
        if (MemAddr[i] == mem_addr) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) mem_words[i][8*b +: 8] <= mem_data_in[8*b +: 8];
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One data-port transaction starting in IDLE, checked through ACCESS and RESP
  task automatic data_op(input string tag, input logic wr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] exp_be, input logic exp_wr,
                         input logic [31:0] exp_din, input logic [31:0] exp_rdata,
                         input logic exp_err);
    d_req = 1'b1; d_wr = wr; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wdata;
    #1;
    check({tag, "_d_gnt"}, d_gnt, 1);
    check({tag, "_if_gnt"}, if_gnt, 0);
    tick();
    d_req = 1'b0;
    #1;
    check({tag, "_be"}, mem_byte_enable, exp_be);
    check({tag, "_mem_wr"}, mem_wr, exp_wr);
    if (wr) check({tag, "_din"}, mem_data_in, exp_din);
    if (!exp_err) check({tag, "_maddr"}, mem_addr, addr);
    tick();
    check({tag, "_rvalid"}, d_rvalid, 1);
    check({tag, "_rdata"}, d_rdata, exp_rdata);
    check({tag, "_err"}, d_err, exp_err);
    check({tag, "_resp_wr"}, mem_wr, 0);
    tick();
    check({tag, "_rvalid_end"}, d_rvalid, 0);
  endtask

  logic exp_data;

  initial begin
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'b10; d_signed = 1'b0;
    d_addr = 32'h300; d_wdata = '0;

    // Reset holds everything low even with both requests pending
    #12;
    check("rst_if_gnt", if_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_be", mem_byte_enable, 0);
    check("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    check("rst_rdata", d_rdata | if_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;

    // Both requesting continuously: one grant every three cycles
    for (int g = 0; g < 8; g++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_data = ((g % 2) == 0);
`else
      exp_data = ((g % 4) != 3);
`endif
      check("arb_d_gnt", d_gnt, exp_data);
      check("arb_if_gnt", if_gnt, !exp_data);
      tick();
      tick();
      check("arb_d_rvalid", d_rvalid, exp_data);
      check("arb_if_rvalid", if_rvalid, !exp_data);
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // Fetch of 0x100: gnt at N, lanes at N+1, data at N+2
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    check("f_if_gnt", if_gnt, 1);
    check("f_d_gnt", d_gnt, 0);
    tick();
    if_req = 1'b0;
    #1;
    check("f_be", mem_byte_enable, 4'b1111);
    check("f_maddr", mem_addr, 32'h100);
    check("f_mem_wr", mem_wr, 0);
    check("f_early_rvalid", if_rvalid, 0);
    tick();
    check("f_rvalid", if_rvalid, 1);
    check("f_rdata", if_rdata, 32'hDEADBEEF);
    check("f_d_rvalid", d_rvalid, 0);
    check("f_resp_be", mem_byte_enable, 0);
    tick();
    check("f_rvalid_end", if_rvalid, 0);
    check("f_idle_maddr", mem_addr, 0);

    data_op("lb_s", 0, 2'b00, 1, 32'h203, 0, 4'b0001, 0, 0, 32'hFFFFFF80, 0);
    data_op("lb_u", 0, 2'b00, 0, 32'h203, 0, 4'b0001, 0, 0, 32'h00000080, 0);
    data_op("lh_s", 0, 2'b01, 1, 32'h204, 0, 4'b0011, 0, 0, 32'hFFFF8001, 0);
    data_op("lh_u", 0, 2'b01, 0, 32'h204, 0, 4'b0011, 0, 0, 32'h00008001, 0);
    data_op("lw_s", 0, 2'b10, 1, 32'h208, 0, 4'b1111, 0, 0, 32'h80000001, 0);
    data_op("sw", 1, 2'b10, 0, 32'h20C, 32'hCAFEF00D, 4'b1111, 1, 32'hCAFEF00D, 0, 0);
    check("sw_mem", mem_words[4], 32'hCAFEF00D);
    data_op("lw_back", 0, 2'b10, 0, 32'h20C, 0, 4'b1111, 0, 0, 32'hCAFEF00D, 0);
    data_op("sb", 1, 2'b00, 0, 32'h210, 32'h123456A5, 4'b0001, 1, 32'h000000A5, 0, 0);
    check("sb_mem", mem_words[5], 32'h112233A5);
    data_op("sh_mis", 1, 2'b01, 0, 32'h201, 32'h1234, 4'b0000, 0, 0, 0, 1);
    check("sh_mis_mem", mem_words[6], 32'h55667788);
    data_op("lw_mis", 0, 2'b10, 0, 32'h202, 0, 4'b0000, 0, 0, 0, 1);
    data_op("res", 0, 2'b11, 0, 32'h208, 0, 4'b0000, 0, 0, 0, 1);

    // Reset in the middle of a word store's ACCESS cycle
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'b10; d_signed = 1'b0;
    d_addr = 32'h20C; d_wdata = 32'h0BADBEEF;
    #1;
    check("rs_d_gnt", d_gnt, 1);
    tick();
    check("rs_pre_wr", mem_wr, 1);
    rst = 1'b0;
    #1;
    check("rs_mem_wr", mem_wr, 0);
    check("rs_be", mem_byte_enable, 0);
    check("rs_maddr", mem_addr, 0);
    check("rs_din", mem_data_in, 0);
    check("rs_d_gnt_gated", d_gnt, 0);
    d_req = 1'b0;
    tick();
    check("rs_no_rvalid0", d_rvalid, 0);
    tick();
    check("rs_no_rvalid1", d_rvalid, 0);
    check("rs_mem_kept", mem_words[4], 32'hCAFEF00D);
    rst = 1'b1;
    #1;
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    check("rs_idle_gnt", if_gnt, 1);
    tick();
    if_req = 1'b0;
    #1;
    check("rs_f_be", mem_byte_enable, 4'b1111);
    tick();
    check("rs_f_rdata", if_rdata, 32'hDEADBEEF);
    check("rs_f_no_d", d_rvalid, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
